// File: rtl/angle_step_ctrl.sv
// Purpose : paces and supervises the sawtooth angle generator from sparse angle samples.
// Latency : every output is registered; a sample strobed at edge k shows load/theta_load in cycle k+1.
// Backpr. : none; samples are accepted whenever they arrive, and load always wins over step.
//
// Ports:
//   clk, RESET_N     - clock, asynchronous active-low reset
//   enable           - run request; low forces IDLE
//   freq[1:0]        - 0: 60 Hz, 1: 50 Hz, 2: step every clock, 3: external pacing (no steps)
//   theta_valid/in   - one-cycle strobe qualifying a 10-bit measured angle
//   step, load       - one-cycle generator commands (never high together)
//   theta_load[9:0]  - accepted sample delivered with load
//   seq_dir          - 1 forward, 0 reverse
//   locked, timeout  - TRACK / HOLDOVER indicators
//   state[1:0]       - 0 IDLE, 1 ACQUIRE, 2 TRACK, 3 HOLDOVER
module angle_step_ctrl #(
   parameter int unsigned TIMEOUT_STEPS = 1024,
   parameter int unsigned HOLD_STEPS    = 4096
) (
   input  logic       clk,
   input  logic       RESET_N,
   input  logic       enable,
   input  logic [1:0] freq,
   input  logic       theta_valid,
   input  logic [9:0] theta_in,
   output logic       step,
   output logic       load,
   output logic [9:0] theta_load,
   output logic       seq_dir,
   output logic       locked,
   output logic       timeout,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_TRACK    = 2'd2,
      ST_HOLDOVER = 2'd3
   } state_e;

   localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_STEPS);
   localparam logic [15:0] GIVEUP_LIM  = 16'(TIMEOUT_STEPS + HOLD_STEPS);

   state_e      state_q, state_d;
   logic        step_q, step_d;
   logic        load_q, load_d;
   logic [9:0]  theta_load_q, theta_load_d;
   logic        seq_dir_q, seq_dir_d;
   logic        locked_q, locked_d;
   logic        timeout_q, timeout_d;
   logic [8:0]  presc_q, presc_d;
   logic [15:0] silence_q, silence_d;
   logic [9:0]  last_theta_q, last_theta_d;
   logic        have_last_q, have_last_d;
   logic [1:0]  agree_q, agree_d;

   logic [8:0]  max_count;
   logic        term_cnt;
   logic [9:0]  delta;
   logic        dir_fwd;
   logic        dir_rev;
   logic        accept;
   logic        opposite;
   logic        running_d;

   always_comb begin
      max_count = 9'd408;
      case (freq)
         2'd1:    max_count = 9'd489;
         2'd2:    max_count = 9'd0;
         default: max_count = 9'd408;
      endcase
   end

   // ">=" rather than "==" so a freq change that leaves the count above the
   // new terminal value clears the prescaler on the very next edge.
   assign term_cnt = (presc_q >= max_count);

   // Modulo-1024 difference; 0 and 512 carry no direction information.
   assign delta    = theta_in - last_theta_q;
   assign dir_fwd  = (delta != 10'd0) && !delta[9];
   assign dir_rev  = delta[9] && (delta != 10'd512);
   assign opposite = seq_dir_q ? dir_rev : dir_fwd;

   // Samples are ignored while disabled or while still sitting in IDLE.
   assign accept   = enable && theta_valid && (state_q != ST_IDLE);

   always_comb begin
      state_d      = state_q;
      load_d       = 1'b0;
      theta_load_d = theta_load_q;
      seq_dir_d    = seq_dir_q;
      agree_d      = agree_q;
      last_theta_d = last_theta_q;
      have_last_d  = have_last_q;

      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               if (accept && have_last_q && (dir_fwd || dir_rev)) begin
                  load_d    = 1'b1;
                  seq_dir_d = dir_fwd;
                  agree_d   = 2'd0;
                  state_d   = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (accept) begin
                  load_d = 1'b1;
                  // Direction needs three consecutive opposing deltas to flip.
                  if (opposite) begin
                     if (agree_q == 2'd2) begin
                        seq_dir_d = ~seq_dir_q;
                        agree_d   = 2'd0;
                     end else begin
                        agree_d = agree_q + 2'd1;
                     end
                  end else begin
                     agree_d = 2'd0;
                  end
               end else if (silence_q >= TIMEOUT_LIM) begin
                  state_d = ST_HOLDOVER;
               end
            end
            ST_HOLDOVER: begin
               if (accept) begin
                  load_d  = 1'b1;
                  agree_d = 2'd0;
                  state_d = ST_TRACK;
               end else if (silence_q >= GIVEUP_LIM) begin
                  state_d = ST_ACQUIRE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (state_q == ST_IDLE) begin
         have_last_d = 1'b0;
      end
      if (accept) begin
         last_theta_d = theta_in;
         have_last_d  = 1'b1;
      end
      if (load_d) begin
         theta_load_d = theta_in;
      end
   end

   // Step is gated on the state being entered so that the last HOLDOVER
   // cycle before giving up emits no pulse, while TRACK->HOLDOVER keeps pacing.
   assign running_d = (state_d == ST_TRACK) || (state_d == ST_HOLDOVER);

   always_comb begin
      step_d = term_cnt && running_d && (freq != 2'd3) && !load_d;

      presc_d = presc_q + 9'd1;
      if ((state_d == ST_IDLE) || load_d || term_cnt) begin
         presc_d = 9'd0;
      end

      silence_d = silence_q;
      if ((state_d == ST_IDLE) || accept) begin
         silence_d = 16'd0;
      end else if (step_d && (silence_q != 16'hFFFF)) begin
         silence_d = silence_q + 16'd1;
      end

      locked_d  = (state_d == ST_TRACK);
      timeout_d = (state_d == ST_HOLDOVER);
   end

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= ST_IDLE;
         step_q       <= 1'b0;
         load_q       <= 1'b0;
         theta_load_q <= 10'd0;
         seq_dir_q    <= 1'b1;
         locked_q     <= 1'b0;
         timeout_q    <= 1'b0;
         presc_q      <= 9'd0;
         silence_q    <= 16'd0;
         last_theta_q <= 10'd0;
         have_last_q  <= 1'b0;
         agree_q      <= 2'd0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         load_q       <= load_d;
         theta_load_q <= theta_load_d;
         seq_dir_q    <= seq_dir_d;
         locked_q     <= locked_d;
         timeout_q    <= timeout_d;
         presc_q      <= presc_d;
         silence_q    <= silence_d;
         last_theta_q <= last_theta_d;
         have_last_q  <= have_last_d;
         agree_q      <= agree_d;
      end
   end

   assign step       = step_q;
   assign load       = load_q;
   assign theta_load = theta_load_q;
   assign seq_dir    = seq_dir_q;
   assign locked     = locked_q;
   assign timeout    = timeout_q;
   assign state      = state_q;

endmodule

// File: doc/angle_step_ctrl.md
# angle_step_ctrl

Pacing and supervision controller for the sawtooth angle generator. Turns sparse measured-angle samples into generator commands. It issues one-cycle `step` pulses at the line-frequency-derived rate, `load` pulses that re-phase the generator to a fresh sample, and a sequence-direction bit derived from consecutive samples. It also tracks lock, timeout and holdover, so the generator keeps running through short sample outages and stops cleanly after long ones.

## Interface
Parameters:
- `TIMEOUT_STEPS`, default 1024: number of step pulses without a sample before the block enters HOLDOVER (1024 steps is one electrical cycle).
- `HOLD_STEPS`, default 4096: further step pulses without a sample before HOLDOVER gives up and returns to ACQUIRE.

Ports:
- `clk` input 1: single clock.
- `RESET_N` input 1: asynchronous, active-low reset.
- `enable` input 1: run request. Low forces IDLE.
- `freq` input 2: 0 = 60 Hz (max_count 408), 1 = 50 Hz (489), 2 = simulation, step every clock (0), 3 = external pacing, no steps (408).
- `theta_valid` input 1: one-cycle strobe marking a new measured angle.
- `theta_in` input 10: measured angle, 0..1023, qualified by `theta_valid`.
- `step` output 1: one-cycle pulse; the generator advances one count.
- `load` output 1: one-cycle pulse; the generator loads `theta_load`.
- `theta_load` output 10: registered copy of the accepted sample.
- `seq_dir` output 1: 1 = forward (increment), 0 = reverse.
- `locked` output 1: high in TRACK only.
- `timeout` output 1: high in HOLDOVER only.
- `state` output 2: 0 IDLE, 1 ACQUIRE, 2 TRACK, 3 HOLDOVER.

## Operation
- Reset values: `state`=IDLE; `step`=0, `load`=0, `locked`=0, `timeout`=0; `theta_load`=0; `seq_dir`=1; prescaler=0; silence counter=0; `last_theta`=0; `have_last`=0; agreement counter=0.
- Delta is computed as `delta = theta_in - last_theta`, 10-bit modulo.
  - 1..511 means forward.
  - 513..1023 means reverse.
  - 0 or 512 is ambiguous and changes no direction state.
  - Every accepted sample updates `last_theta` and sets `have_last`.
- Prescaler: 9-bit, counts 0..max_count. At terminal count it clears and produces a `step` (TRACK/HOLDOVER only).
  - `freq`=2: `step` every cycle.
  - `freq`=3: the prescaler runs but `step` is never asserted.
- Silence counter: 16-bit, saturating. Increments on each `step` and clears on any accepted `theta_valid`.
- FSM:
  - IDLE: no `step` or `load`; `have_last` is cleared. `enable`=1 -> ACQUIRE.
  - ACQUIRE: no `step` or `load`.
    - A sample with `have_last`=0 is only recorded.
    - A sample with a non-ambiguous delta sets `seq_dir` directly, issues `load`, and goes to TRACK.
    - An ambiguous delta stays in ACQUIRE.
  - TRACK: free-running `step`.
    - Each sample issues `load` and clears the prescaler.
    - `seq_dir` flips only after 3 consecutive samples opposite to the current `seq_dir`. An agreeing or ambiguous delta resets the agreement counter.
    - Silence counter reaching `TIMEOUT_STEPS` -> HOLDOVER.
  - HOLDOVER: `step` continues at the same rate; `seq_dir` is frozen.
    - A sample issues `load` -> TRACK, silence counter cleared.
    - Silence counter reaching `TIMEOUT_STEPS`+`HOLD_STEPS` -> ACQUIRE, with `have_last` kept.
- `enable`=0 in any state -> IDLE on the next edge. A `step` or `load` already registered still completes its single cycle.

## Timing
- All outputs are registered.
- A sample strobed at edge k gives `load`, `theta_load` and any `seq_dir` change high/valid in cycle k+1.
- `step` is high in the cycle after the prescaler hits terminal count. The pulse period is max_count+1 clocks: 409 at 60 Hz, 490 at 50 Hz.
- Simultaneous `theta_valid` and terminal count: `load` wins, `step` is suppressed, and the prescaler restarts at 0. `step` and `load` are never high together.
- A change of `freq` takes effect at the next prescaler clear. If the current count exceeds the new max_count, the prescaler clears immediately.
- `RESET_N` asserted mid-operation clears all state asynchronously. Deassertion is synchronized externally; the first active edge sees IDLE.

## Test plan
- Reset, then `enable`=1 with no samples: `state`=ACQUIRE, `step`=0 indefinitely, `locked`=0, `seq_dir`=1.
- `freq`=0, samples 100 then 110: `load`=1 with `theta_load`=110 one cycle after the second strobe; `state`=TRACK; `step` period is exactly 409 clocks. Repeat with `freq`=1: period 490.
- In TRACK forward, samples 200, 150, 100, 50: `seq_dir` goes 0 only after the third reverse delta. A sample of 562 after 50 (delta 512) causes no change.
- `freq`=2, TRACK, then stop samples: `timeout`=1 in the cycle after the 1024th `step`. After 4096 more steps, `state`=ACQUIRE and `step` stops. A sample during HOLDOVER returns `state`=TRACK with a `load`.
- Strobe `theta_valid` on the terminal-count cycle: `load`=1, `step`=0 that cycle, next `step` after max_count+1 clocks. Pulse `RESET_N` low mid-TRACK: all outputs read their reset values immediately.
